sram_wr_sched: RTL and testbench
================================

// Module: sram_wr_sched
// PURPOSE
//  Write-port scheduler for one SRAM bank of the multi-port cache. Shares the bank's
//  single write path (the block-address/valid interface of the bank write stage) among
//  PORT_NUM ingress FIFOs. Grants one requester at a time, round-robin. Once granted,
//  a requester holds the path for its whole burst. One block address is issued per cycle.
//  It drives per-port FIFO read enables so that the write stage sees the granted FIFO's data.
// PARAMETERS
//  PORT_NUM   8                 number of requesting ingress ports (>=2)
//  ADDR_W     `BLK_ADDR_WIDTH   SRAM block-address width
//  LEN_W      6                 burst-length field width; burst = len+1 words (1..2^LEN_W)
// PORTS
//  i_clk            in   1                 clock; single clock domain
//  i_rst_n          in   1                 asynchronous, active-low reset
//  i_req            in   PORT_NUM          per-port burst request, level
//  i_base_addr      in   PORT_NUM*ADDR_W   per-port burst start block address (port p at [p*ADDR_W +: ADDR_W])
//  i_len            in   PORT_NUM*LEN_W    per-port burst length minus one
//  o_ack            out  PORT_NUM          one-cycle pulse: request accepted (one-hot)
//  o_done           out  PORT_NUM          one-cycle pulse: last word of that port's burst issued
//  o_fifo_ren       out  PORT_NUM          per-port FIFO read enable = o_sram_addr_vld & o_grant
//  o_grant          out  PORT_NUM          one-hot owner of the write path; 0 when idle
//  o_sram_addr      out  ADDR_W            block address to bank write stage
//  o_sram_addr_vld  out  1                 address valid; one SRAM word written per valid cycle
//  o_busy           out  1                 high while in BURST
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, round-robin pointer = port 0, counters 0.
//    Reset mid-burst abandons the burst: no o_done, no further valids.
//  - FSM, two states:
//    IDLE: if any i_req, pick winner w = first set bit at or after rr_ptr (wrapping).
//          Next edge: state=BURST, o_grant=onehot(w), o_ack[w]=1 (single cycle),
//          o_sram_addr=base[w], o_sram_addr_vld=1, cnt=len[w], cur=base[w].
//          Base and len are captured at this edge. Later changes to them are ignored.
//    BURST: each cycle o_sram_addr_vld=1. If cnt!=0, next edge: addr=cur+1 (mod 2^ADDR_W), cnt-=1.
//          If cnt==0 (current word is last): o_done[w]=1 this cycle (registered with the last word).
//          Next edge: state=IDLE, o_grant=0, vld=0, rr_ptr=(w+1) mod PORT_NUM.
//  - Latency: request seen in IDLE cycle t -> first address/valid/ack in t+1, last word in t+1+len.
//  - Bubble: exactly one IDLE cycle (vld=0) between consecutive bursts.
//  - Handshake: a requester keeps i_req, i_base_addr, i_len stable until it sees o_ack.
//    It deasserts i_req in the cycle after o_ack, unless it has a new burst.
//    i_req is never used during BURST.
//  - o_fifo_ren is combinational from registered o_sram_addr_vld & o_grant. Data from the
//    granted FIFO arrives with the same timing the write stage already expects.
//  - Address wrap: ADDR_W-bit increment wraps 2^ADDR_W-1 -> 0 silently.
//  - len=0: single-word burst. ack and done both assert in the same cycle.
//  - Simultaneous requests: strictly round-robin from rr_ptr. A port that was just
//    served has lowest priority next arbitration.
//  - Request on the granted port during BURST is ignored. It is arbitrated at the next IDLE.
// STRUCTURE
//  - Shared header/package (mpcache.svh): PORT_NUM, LEN_W, `BLK_ADDR_WIDTH,
//    typedef enum logic {SCH_IDLE, SCH_BURST} sch_state_e.
//  - One sub-module: rr_arbiter #(N) — combinational (req, ptr) -> one-hot grant + index.
//    Reused by the read-side scheduler.
//  - Top: FSM, address/count registers, rr_ptr, output registers.
// TESTING
//  1 Single: port 3 req, base=0x010, len=3 -> ack[3] at t+1; addrs 0x010..0x013 t+1..t+4;
//    done[3] at t+4; fifo_ren[3] 4 cycles.
//  2 Contention: ports 0,2,5 req together at rr_ptr=0 -> served 0,2,5 in order, one idle
//    cycle between bursts, rr_ptr=6 at end.
//  3 Fairness: all 8 ports req continuously (re-requesting after ack) -> grants cycle 0..7,0..;
//    no port granted twice within 8 bursts.
//  4 Wrap: base=2^ADDR_W-2, len=3 -> addrs MAX-1, MAX, 0, 1; done on addr 1.
//  5 Min burst: len=0 on port 7 -> ack[7] and done[7] same cycle, exactly one vld, then IDLE.
//  6 Reset mid-burst: assert i_rst_n=0 at word 2 of len=5 -> all outputs 0 asynchronously,
//    no done; after release, a port 0 req is served from rr_ptr=0.

Source files
------------

// File: rtl/sram_wr_sched_pkg.sv
// Shared types and sizing for the SRAM bank write-port scheduler.
// Reused by the read-side scheduler through the same arbiter and state type.
package sram_wr_sched_pkg;

  localparam int PORT_NUM       = 8;
  localparam int LEN_W          = 6;
  localparam int BLK_ADDR_WIDTH = 10;
  localparam int ADDR_W         = BLK_ADDR_WIDTH;
  localparam int IDX_W          = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic {SCH_IDLE, SCH_BURST} sch_state_e;

endpackage

// File: rtl/sram_wr_sched_if.sv
// Request/burst bus between the ingress FIFOs and the bank write stage.
// The master side holds the requesters; the slave side is the scheduler.
interface sram_wr_sched_if;
  import sram_wr_sched_pkg::*;

  logic [PORT_NUM-1:0]        i_req;
  logic [PORT_NUM*ADDR_W-1:0] i_base_addr;
  logic [PORT_NUM*LEN_W-1:0]  i_len;
  logic [PORT_NUM-1:0]        o_ack;
  logic [PORT_NUM-1:0]        o_done;
  logic [PORT_NUM-1:0]        o_fifo_ren;
  logic [PORT_NUM-1:0]        o_grant;
  logic [ADDR_W-1:0]          o_sram_addr;
  logic                       o_sram_addr_vld;
  logic                       o_busy;

  modport master (
    output i_req, i_base_addr, i_len,
    input  o_ack, o_done, o_fifo_ren, o_grant, o_sram_addr, o_sram_addr_vld, o_busy
  );

  modport slave (
    input  i_req, i_base_addr, i_len,
    output o_ack, o_done, o_fifo_ren, o_grant, o_sram_addr, o_sram_addr_vld, o_busy
  );

endinterface

// File: rtl/sram_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, wrapping.
// Returns the winner both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    int            sum;
    logic [IW-1:0] j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    sum     = 0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(i_ptr) + i;
      if (sum >= N) sum = sum - N;
      j = IW'(sum);
      if (!o_valid && i_req[j]) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = j;
      end
    end
  end

endmodule

// File: rtl/sram_wr_sched.sv
// Round-robin write-port scheduler for one SRAM bank: grants one ingress FIFO at a
// time for a whole burst and issues one block address per cycle to the write stage.
module sram_wr_sched
  import sram_wr_sched_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  sram_wr_sched_if.slave bus
);

  sch_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [PORT_NUM-1:0] ack_q, ack_d;
  logic [PORT_NUM-1:0] done_q, done_d;
  logic                vld_q, vld_d;

  logic [PORT_NUM-1:0] arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  logic [ADDR_W-1:0]   base_arr [PORT_NUM];
  logic [LEN_W-1:0]    len_arr  [PORT_NUM];

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_unpack
    assign base_arr[g] = bus.i_base_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = bus.i_len[g*LEN_W +: LEN_W];
  end

  rr_arbiter #(.N(PORT_NUM), .IW(IDX_W)) u_arb (
    .i_req   (bus.i_req),
    .i_ptr   (rr_ptr_q),
    .o_grant (arb_grant),
    .o_idx   (arb_idx),
    .o_valid (arb_valid)
  );

  // Arbitration result is only consulted in IDLE, so requests during a burst wait.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    grant_d  = grant_q;
    vld_d    = vld_q;
    ack_d    = '0;
    done_d   = '0;
    case (state_q)
      SCH_IDLE: begin
        if (arb_valid) begin
          state_d = SCH_BURST;
          grant_d = arb_grant;
          ack_d   = arb_grant;
          idx_d   = arb_idx;
          addr_d  = base_arr[arb_idx];
          cnt_d   = len_arr[arb_idx];
          vld_d   = 1'b1;
          done_d  = (len_arr[arb_idx] == '0) ? arb_grant : '0;
        end
      end
      SCH_BURST: begin
        if (cnt_q != '0) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          done_d = (cnt_q == LEN_W'(1)) ? grant_q : '0;
        end else begin
          state_d  = SCH_IDLE;
          grant_d  = '0;
          vld_d    = 1'b0;
          rr_ptr_d = (idx_q == IDX_W'(PORT_NUM - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= SCH_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.o_grant         = grant_q;
  assign bus.o_ack           = ack_q;
  assign bus.o_done          = done_q;
  assign bus.o_sram_addr     = addr_q;
  assign bus.o_sram_addr_vld = vld_q;
  assign bus.o_busy          = (state_q == SCH_BURST);
  assign bus.o_fifo_ren      = grant_q & {PORT_NUM{vld_q}};

endmodule

// File: tb/tb_sram_wr_sched.sv
// Bench for sram_wr_sched: a cycle-schedule model of planned bursts checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_sram_wr_sched;
  import sram_wr_sched_pkg::*;

  typedef struct packed {
    logic                idle;
    logic [PORT_NUM-1:0] grant;
    logic [ADDR_W-1:0]   addr;
    logic                ack;
    logic                done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks_total;
  int   checks_passed;
  int   m_ptr;
  int   ack_log[$];
  exp_t exp_q[$];
  logic [PORT_NUM-1:0] sticky;

  sram_wr_sched_if bus ();

  sram_wr_sched dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int p, input int base, input int len);
    bus.i_base_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(base);
    bus.i_len[p*LEN_W +: LEN_W]         = LEN_W'(len);
    bus.i_req[p]                        = 1'b1;
  endtask

  // Advance to just after the next rising edge; requesters drop i_req once acked.
  task automatic stepCycle();
    @(posedge clk);
    #2;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (bus.o_ack[p]) begin
        ack_log.push_back(p);
        if (!sticky[p]) bus.i_req[p] = 1'b0;
      end
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_hs"}, {bus.o_ack, bus.o_done, bus.o_grant, bus.o_fifo_ren}, 32'h0);
    checkOutput({name, "_bus"}, 32'({bus.o_busy, bus.o_sram_addr_vld, bus.o_sram_addr}), 32'h0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    checkAllZero("reset_async");
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    ack_log.delete();
  endtask

  // Whenever the scheduler is idle, plan the winner's whole burst plus one bubble.
  task automatic modelLoop();
    exp_t e;
    exp_t idle_e;
    int   w;
    int   l;
    logic [ADDR_W-1:0]   b;
    logic [PORT_NUM-1:0] exp_ack, exp_done, exp_ren;
    idle_e      = '0;
    idle_e.idle = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_ptr = 0;
        checkAllZero("model_reset");
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e;
        exp_ack  = e.ack  ? e.grant : '0;
        exp_done = e.done ? e.grant : '0;
        exp_ren  = e.idle ? '0 : e.grant;
        checkOutput("model_vld", 32'(bus.o_sram_addr_vld), 32'(!e.idle));
        checkOutput("model_busy", 32'(bus.o_busy), 32'(!e.idle));
        checkOutput("model_grant", 32'(bus.o_grant), 32'(e.grant));
        checkOutput("model_ack", 32'(bus.o_ack), 32'(exp_ack));
        checkOutput("model_done", 32'(bus.o_done), 32'(exp_done));
        checkOutput("model_fifo_ren", 32'(bus.o_fifo_ren), 32'(exp_ren));
        if (!e.idle) checkOutput("model_addr", 32'(bus.o_sram_addr), 32'(e.addr));
        if (e.idle && bus.i_req != '0) begin
          w = 0;
          for (int k = 0; k < PORT_NUM; k++) begin
            if (bus.i_req[(m_ptr + k) % PORT_NUM]) begin
              w = (m_ptr + k) % PORT_NUM;
              break;
            end
          end
          b = bus.i_base_addr[w*ADDR_W +: ADDR_W];
          l = int'(bus.i_len[w*LEN_W +: LEN_W]);
          for (int k = 0; k <= l; k++) begin
            exp_t n;
            n.idle  = 1'b0;
            n.grant = PORT_NUM'(1) << w;
            n.addr  = b + ADDR_W'(k);
            n.ack   = (k == 0);
            n.done  = (k == l);
            exp_q.push_back(n);
          end
          exp_q.push_back(idle_e);
          m_ptr = (w + 1) % PORT_NUM;
        end
      end
    end
  endtask

  initial begin
    int exp2[3];
    exp2 = '{0, 2, 5};
    checks_total     = 0;
    checks_passed    = 0;
    m_ptr            = 0;
    sticky           = '0;
    bus.i_req        = '0;
    bus.i_base_addr  = '0;
    bus.i_len        = '0;
    rst_n            = 1'b1;
    fork
      modelLoop();
      begin
        #1 rst_n = 1'b0;
        #1 checkAllZero("reset_state");
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();

        $display("[TB] single burst on port 3");
        applyStimulus(3, 'h010, 3);
        stepCycle();
        checkOutput("t1_ack", 32'(bus.o_ack), 32'h08);
        checkOutput("t1_addr0", 32'(bus.o_sram_addr), 32'h010);
        checkOutput("t1_ren0", 32'(bus.o_fifo_ren), 32'h08);
        bus.i_base_addr[3*ADDR_W +: ADDR_W] = ADDR_W'('h2AA);
        for (int k = 1; k <= 3; k++) begin
          stepCycle();
          checkOutput("t1_addr", 32'(bus.o_sram_addr), 32'h010 + 32'(k));
        end
        checkOutput("t1_done", 32'(bus.o_done), 32'h08);
        stepCycle();
        checkOutput("t1_idle_vld", 32'(bus.o_sram_addr_vld), 32'h0);

        $display("[TB] contention on ports 0,2,5");
        resetDut();
        applyStimulus(0, 'h020, 1);
        applyStimulus(2, 'h040, 2);
        applyStimulus(5, 'h060, 0);
        repeat (14) stepCycle();
        checkOutput("t2_ack_count", 32'(ack_log.size()), 32'd3);
        for (int k = 0; k < 3; k++)
          checkOutput("t2_order", (k < ack_log.size()) ? 32'(ack_log[k]) : 32'hFF, 32'(exp2[k]));

        $display("[TB] fairness with all ports requesting");
        ack_log.delete();
        for (int p = 0; p < PORT_NUM; p++) applyStimulus(p, p * 16, 1);
        sticky = '1;
        for (int c = 0; c < 100 && ack_log.size() < 16; c++) stepCycle();
        bus.i_req = '0;
        sticky    = '0;
        checkOutput("t3_ack_count", 32'(ack_log.size()), 32'd16);
        for (int k = 0; k < 16; k++)
          checkOutput("t3_order", (k < ack_log.size()) ? 32'(ack_log[k]) : 32'hFF, 32'((6 + k) % 8));
        repeat (4) stepCycle();

        $display("[TB] address wrap on port 1");
        applyStimulus(1, 'h3FE, 3);
        stepCycle();
        checkOutput("t4_addr0", 32'(bus.o_sram_addr), 32'h3FE);
        stepCycle();
        checkOutput("t4_addr1", 32'(bus.o_sram_addr), 32'h3FF);
        stepCycle();
        checkOutput("t4_addr2", 32'(bus.o_sram_addr), 32'h000);
        stepCycle();
        checkOutput("t4_addr3", 32'(bus.o_sram_addr), 32'h001);
        checkOutput("t4_done", 32'(bus.o_done), 32'h02);
        stepCycle();

        $display("[TB] single-word burst on port 7");
        applyStimulus(7, 'h155, 0);
        stepCycle();
        checkOutput("t5_ack", 32'(bus.o_ack), 32'h80);
        checkOutput("t5_done", 32'(bus.o_done), 32'h80);
        checkOutput("t5_vld", 32'(bus.o_sram_addr_vld), 32'h1);
        stepCycle();
        checkOutput("t5_after_vld", 32'(bus.o_sram_addr_vld), 32'h0);
        checkOutput("t5_after_grant", 32'(bus.o_grant), 32'h0);
        stepCycle();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(2, 'h100, 5);
        stepCycle();
        stepCycle();
        checkOutput("t6_word2_addr", 32'(bus.o_sram_addr), 32'h101);
        resetDut();
        applyStimulus(0, 'h030, 1);
        applyStimulus(5, 'h050, 1);
        stepCycle();
        checkOutput("t6_first_ack", 32'(bus.o_ack), 32'h01);
        repeat (8) stepCycle();
      end
    join_any
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
